// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, fetches from imem over req/ack and hands words to decode over valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redir_valid,
  input  logic        redir_type,
  input  logic [31:0] redir_pc,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_jba
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] redir_pc4;
  logic [31:0] target;
  assign redir_pc4 = redir_pc + 32'd4;
  assign target    = redir_type ? {redir_pc4[31:28], redir_jba, 2'b00}
                                : redir_pc4 + {{14{redir_imm[15]}}, redir_imm, 2'b00};
  assign imem_addr = pc;
  // DRAIN keeps the old address on the bus until memory acks, so the handshake is never violated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend_pc    <= 32'd0;
      imem_req   <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (redir_valid && imem_ack) begin
            pc <= target;
          end else if (redir_valid) begin
            pend_pc <= target;
            state   <= DRAIN;
          end else if (imem_ack) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            pc         <= pc + 32'd4;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (redir_valid) begin
            inst_valid <= 1'b0;
            pc         <= target;
            imem_req   <= 1'b1;
            state      <= REQ;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= REQ;
          end
        end
        DRAIN: begin
          if (redir_valid) pend_pc <= target;
          if (imem_ack) begin
            pc    <= redir_valid ? target : pend_pc;
            state <= REQ;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios with a scoreboard of fetched {pc, word} pairs.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic        redir_type = 1'b0;
  logic [31:0] redir_pc = 32'd0;
  logic [15:0] redir_imm = 16'd0;
  logic [25:0] redir_jba = 26'd0;
  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_e;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .redir_valid(redir_valid),
    .redir_type(redir_type), .redir_pc(redir_pc), .redir_imm(redir_imm), .redir_jba(redir_jba)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives an ack for the current address; keep says whether decode should see the word
  task automatic ack_cycle(input logic [31:0] a, input bit keep);
    imem_ack   = 1'b1;
    imem_rdata = mem(a);
    if (keep) sb.push_back({a, mem(a)});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  task automatic redirect(input logic t, input logic [31:0] p, input logic [15:0] imm, input logic [25:0] jba);
    redir_valid = 1'b1;
    redir_type  = t;
    redir_pc    = p;
    redir_imm   = imm;
    redir_jba   = jba;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({imem_req, inst_valid, imem_addr, inst, inst_pc} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: req=%b valid=%b addr=%h inst=%h inst_pc=%h, want all zero", imem_req, inst_valid, imem_addr, inst, inst_pc);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(i * 4)}) begin
        n_fail++;
        $display("FAIL stream_addr[%0d]: req=%b addr=%h, want 1 %h", i, imem_req, imem_addr, 32'(i * 4));
      end
      ack_cycle(32'(i * 4), 1'b1);
      exp_e = sb.pop_front();
      n_checks++;
      if ({inst_valid, imem_req, inst_pc, inst} !== {1'b1, 1'b0, exp_e}) begin
        n_fail++;
        $display("FAIL stream_inst[%0d]: valid=%b req=%b pc=%h inst=%h, want 1 0 %h %h", i, inst_valid, imem_req, inst_pc, inst, exp_e[63:32], exp_e[31:0]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'hC, 1'b0}) begin
        n_fail++;
        $display("FAIL wait_hold[%0d]: req=%b addr=%h valid=%b, want 1 0000000c 0", i, imem_req, imem_addr, inst_valid);
      end
    end
    inst_ready = 1'b0;
    ack_cycle(32'hC, 1'b1);
    exp_e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({inst_valid, imem_req, inst_pc, inst} !== {1'b1, 1'b0, exp_e}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b req=%b pc=%h inst=%h, want 1 0 %h %h", i, inst_valid, imem_req, inst_pc, inst, exp_e[63:32], exp_e[31:0]);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    n_checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b, want 1 00000010 0", imem_req, imem_addr, inst_valid);
    end
  endtask

  task automatic test_branch_hold();
    inst_ready = 1'b0;
    ack_cycle(32'h10, 1'b0);
    n_checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h10}) begin
      n_fail++;
      $display("FAIL branch_pre: valid=%b pc=%h, want 1 00000010", inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    redirect(1'b0, 32'h100, 16'hFFFE, 26'd0);
    tick();
    redir_valid = 1'b0;
    n_checks++;
    if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'hFC}) begin
      n_fail++;
      $display("FAIL branch_hold: valid=%b req=%b addr=%h, want 0 1 000000fc", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_jump_drain();
    redirect(1'b1, 32'h1000_0000, 16'd0, 26'h40);
    tick();
    redir_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFC}) begin
        n_fail++;
        $display("FAIL jump_drain_hold[%0d]: req=%b addr=%h, want 1 000000fc", i, imem_req, imem_addr);
      end
      tick();
    end
    ack_cycle(32'hFC, 1'b0);
    n_checks++;
    if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h1000_0100}) begin
      n_fail++;
      $display("FAIL jump_target: valid=%b req=%b addr=%h, want 0 1 10000100", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_two_redirects();
    redirect(1'b0, 32'h1FC, 16'd0, 26'd0);
    tick();
    redirect(1'b0, 32'h2FC, 16'd0, 26'd0);
    tick();
    redir_valid = 1'b0;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h1000_0100}) begin
      n_fail++;
      $display("FAIL drain2_hold: req=%b addr=%h, want 1 10000100", imem_req, imem_addr);
    end
    ack_cycle(32'h1000_0100, 1'b0);
    n_checks++;
    if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL drain2_target: valid=%b req=%b addr=%h, want 0 1 00000300", inst_valid, imem_req, imem_addr);
    end
    ack_cycle(32'h300, 1'b1);
    exp_e = sb.pop_front();
    n_checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, exp_e}) begin
      n_fail++;
      $display("FAIL drain2_fetch: valid=%b pc=%h inst=%h, want 1 %h %h", inst_valid, inst_pc, inst, exp_e[63:32], exp_e[31:0]);
    end
    tick();
    redirect(1'b0, 32'h3FC, 16'd0, 26'd0);
    ack_cycle(32'h304, 1'b0);
    redir_valid = 1'b0;
    n_checks++;
    if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h400}) begin
      n_fail++;
      $display("FAIL redir_with_ack: valid=%b req=%b addr=%h, want 0 1 00000400", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_wrap();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, inst_valid, imem_addr} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: req=%b valid=%b addr=%h, want 0 0 00000000", imem_req, inst_valid, imem_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL restart: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    redirect(1'b1, 32'hEFFF_FFFC, 16'd0, 26'h3FF_FFFF);
    ack_cycle(32'h0, 1'b0);
    redir_valid = 1'b0;
    n_checks++;
    if ({inst_valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_target: valid=%b addr=%h, want 0 fffffffc", inst_valid, imem_addr);
    end
    ack_cycle(32'hFFFF_FFFC, 1'b1);
    exp_e = sb.pop_front();
    n_checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, exp_e}) begin
      n_fail++;
      $display("FAIL wrap_fetch: valid=%b pc=%h inst=%h, want 1 %h %h", inst_valid, inst_pc, inst, exp_e[63:32], exp_e[31:0]);
    end
    tick();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_next: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d left, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_hold();
    test_jump_drain();
    test_two_redirects();
    test_reset_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
